// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data/memory port bundle for the shared memory arbiter
interface mem_port_arbiter_if;
  // fetch port
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ready_o;
  logic [31:0] if_data_o;
  // data port
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ready_o;
  logic [31:0] dm_rdata_o;
  // memory side
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  // pipeline
  logic        stall_o;

  // arbiter side
  modport slave (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_ack_i, mem_rdata_i,
    output if_ready_o, if_data_o, dm_ready_o, dm_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
  );

  // pipeline / memory model side
  modport master (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_ack_i, mem_rdata_i,
    input  if_ready_o, if_data_o, dm_ready_o, dm_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - data-priority fetch/data arbiter for one shared variable-latency memory
module mem_port_arbiter #(
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_streak;
  logic        r_if_ready;
  logic [31:0] r_if_data;
  logic        r_dm_ready;
  logic [31:0] r_dm_rdata;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_dm_win;
  logic        w_stall;

  // Data port wins unless a waiting fetch has already been passed over MAX_DM_STREAK times.
  always_comb begin
    w_dm_win = bus.dm_req_i && (!bus.if_req_i || ({28'd0, r_streak} < MAX_DM_STREAK));
    w_stall  = (bus.if_req_i && !r_if_ready) || (bus.dm_req_i && !r_dm_ready);
  end

  // Arbitration FSM: one outstanding memory access, ready pulse in the cycle after ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_streak    <= 4'd0;
      r_if_ready  <= 1'b0;
      r_if_data   <= 32'd0;
      r_dm_ready  <= 1'b0;
      r_dm_rdata  <= 32'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_dm_win) begin
            r_state     <= BUSY_DM;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.dm_we_i;
            r_mem_addr  <= bus.dm_addr_i;
            r_mem_wdata <= bus.dm_wdata_i;
            // The streak only counts grants that made a fetch wait.
            if (bus.if_req_i) begin
              if (r_streak != 4'd15) r_streak <= r_streak + 4'd1;
            end else begin
              r_streak <= 4'd0;
            end
          end else if (bus.if_req_i) begin
            r_state    <= BUSY_IF;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= bus.if_addr_i;
            r_streak   <= 4'd0;
          end else begin
            r_mem_req <= 1'b0;
          end
        end
        BUSY_IF: begin
          if (bus.mem_ack_i) begin
            r_state    <= RESP;
            r_mem_req  <= 1'b0;
            r_if_ready <= 1'b1;
            r_if_data  <= bus.mem_rdata_i;
          end
        end
        BUSY_DM: begin
          if (bus.mem_ack_i) begin
            r_state    <= RESP;
            r_mem_req  <= 1'b0;
            r_dm_ready <= 1'b1;
            if (!r_mem_we) r_dm_rdata <= bus.mem_rdata_i;
          end
        end
        // Requests seen here are the ones just served, so they are not sampled.
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.if_ready_o  = r_if_ready;
  assign bus.if_data_o   = r_if_data;
  assign bus.dm_ready_o  = r_dm_ready;
  assign bus.dm_rdata_o  = r_dm_rdata;
  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;
  assign bus.stall_o     = w_stall;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_DM_STREAK(4)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        ifr;
    logic [31:0] ifa;
    logic        dmr;
    logic        we;
    logic [31:0] dma;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] rd;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_ifr;
    logic [31:0] e_ifd;
    logic        e_dmr;
    logic [31:0] e_dmd;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic rst_v, input logic ifr, input logic [31:0] ifa,
    input logic dmr, input logic we, input logic [31:0] dma, input logic [31:0] wd,
    input logic ack, input logic [31:0] rd,
    input logic e_req, input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wdata,
    input logic e_ifr, input logic [31:0] e_ifd, input logic e_dmr, input logic [31:0] e_dmd);
    vec_t v;
    v = '{rst_v, ifr, ifa, dmr, we, dma, wd, ack, rd,
          e_req, e_we, e_addr, e_wdata, e_ifr, e_ifd, e_dmr, e_dmd};
    return v;
  endfunction

  initial begin
    vec_t         v;
    logic [132:0] got;
    logic [132:0] exp;
    logic         e_stall;
    logic [31:0]  dm_addr;
    logic [31:0]  exp_addr;
    logic         exp_fetch;
    logic         prev_req;
    int           grants;
    int           dm_n;

    // reset with junk inputs, then idle and a stray ack
    tbl.push_back(mk(1,1,32'hAAAA0000,1,1,32'h5555,32'h1234,1,32'hFFFF, 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,0,32'h0,1,0,32'hBEEF,32'h9,1,32'h77,             0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,                                 0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,32'hFFFFFFFF,                      0,0,0,0,0,0,0,0));
    // fetch only, ack three cycles after mem_req rises
    tbl.push_back(mk(0,1,32'h10,0,0,0,0,0,0,           1,0,32'h10,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h10,0,0,0,0,0,0,           1,0,32'h10,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h10,0,0,0,0,0,0,           1,0,32'h10,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h10,0,0,0,0,0,0,           1,0,32'h10,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h10,0,0,0,0,1,32'h00500093,0,0,32'h10,0,1,32'h00500093,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,                0,0,32'h10,0,0,32'h00500093,0,0));
    // simultaneous data read and fetch, ack latency 1
    tbl.push_back(mk(0,1,32'h14,1,0,32'h100,0,0,0,           1,0,32'h100,0,0,32'h00500093,0,0));
    tbl.push_back(mk(0,1,32'h14,1,0,32'h100,0,1,32'hCAFE0001,0,0,32'h100,0,0,32'h00500093,1,32'hCAFE0001));
    tbl.push_back(mk(0,1,32'h14,0,0,0,0,0,0,                 0,0,32'h100,0,0,32'h00500093,0,32'hCAFE0001));
    tbl.push_back(mk(0,1,32'h14,0,0,0,0,0,0,                 1,0,32'h14,0,0,32'h00500093,0,32'hCAFE0001));
    tbl.push_back(mk(0,1,32'h14,0,0,0,0,1,32'h13,            0,0,32'h14,0,1,32'h13,0,32'hCAFE0001));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,                      0,0,32'h14,0,0,32'h13,0,32'hCAFE0001));
    // data write keeps dm_rdata; stray ack in RESP ignored
    tbl.push_back(mk(0,0,0,1,1,32'h200,32'hDEADBEEF,0,0,           1,1,32'h200,32'hDEADBEEF,0,32'h13,0,32'hCAFE0001));
    tbl.push_back(mk(0,0,0,1,1,32'h200,32'hDEADBEEF,1,32'h12345678,0,1,32'h200,32'hDEADBEEF,0,32'h13,1,32'hCAFE0001));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,32'hBAD,                      0,1,32'h200,32'hDEADBEEF,0,32'h13,0,32'hCAFE0001));
    // reset in BUSY_DM, late ack, then normal arbitration
    tbl.push_back(mk(0,0,0,1,0,32'h300,0,0,0,     1,0,32'h300,0,0,32'h13,0,32'hCAFE0001));
    tbl.push_back(mk(1,0,0,1,0,32'h300,0,0,0,     0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,32'h55,      0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h40,0,0,0,0,0,0,      1,0,32'h40,0,0,0,0,0));
    tbl.push_back(mk(0,1,32'h40,0,0,0,0,1,32'h77, 0,0,32'h40,0,1,32'h77,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,           0,0,32'h40,0,0,32'h77,0,0));

    foreach (tbl[i]) begin
      v = tbl[i];
      rst             = v.rst;
      bus.if_req_i    = v.ifr;
      bus.if_addr_i   = v.ifa;
      bus.dm_req_i    = v.dmr;
      bus.dm_we_i     = v.we;
      bus.dm_addr_i   = v.dma;
      bus.dm_wdata_i  = v.wd;
      bus.mem_ack_i   = v.ack;
      bus.mem_rdata_i = v.rd;
      @(posedge clk);
      #1;
      e_stall = (v.ifr & ~v.e_ifr) | (v.dmr & ~v.e_dmr);
      exp = {v.e_req, v.e_we, v.e_addr, v.e_wdata, v.e_ifr, v.e_ifd, v.e_dmr, v.e_dmd, e_stall};
      got = {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.if_ready_o,
             bus.if_data_o, bus.dm_ready_o, bus.dm_rdata_o, bus.stall_o};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL row%0d {req,we,addr,wdata,ifrdy,ifd,dmrdy,dmd,stall} got %h exp %h", i, got, exp);
      end
    end

    // streak limit: both ports request continuously, memory acks immediately
    bus.if_req_i    = 1'b1;
    bus.if_addr_i   = 32'h1000;
    bus.dm_req_i    = 1'b1;
    bus.dm_we_i     = 1'b0;
    bus.dm_wdata_i  = 32'd0;
    dm_addr         = 32'h2000;
    bus.dm_addr_i   = dm_addr;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 32'd0;
    grants   = 0;
    dm_n     = 0;
    prev_req = 1'b0;
    for (int cyc = 0; cyc < 300 && grants < 15; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.dm_ready_o) begin
        dm_addr       = dm_addr + 32'd4;
        bus.dm_addr_i = dm_addr;
      end
      if (bus.mem_req_o && !prev_req) begin
        exp_fetch = ((grants % 5) == 4);
        exp_addr  = exp_fetch ? 32'h1000 : (32'h2000 + 32'(4 * dm_n));
        checks++;
        if (bus.mem_addr_o !== exp_addr || bus.mem_we_o !== 1'b0) begin
          errors++;
          $display("FAIL streak_grant%0d addr %h we %b exp addr %h we 0",
                   grants, bus.mem_addr_o, bus.mem_we_o, exp_addr);
        end
        if (!exp_fetch) dm_n++;
        grants++;
      end
      prev_req        = bus.mem_req_o;
      bus.mem_ack_i   = bus.mem_req_o;
      bus.mem_rdata_i = 32'(cyc);
    end
    checks++;
    if (grants != 15) begin
      errors++;
      $display("FAIL streak_bound grants %0d exp 15", grants);
    end

    bus.if_req_i  = 1'b0;
    bus.dm_req_i  = 1'b0;
    bus.mem_ack_i = 1'b0;
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
